pixie_dma_scheduler: RTL and testbench

PIXIE_DMA_SCHEDULER -- requirements
Module: pixie_dma_scheduler

---
 rtl/pixie_dma_scheduler.sv | 178 +++++++++++++++++
 tb/tb_pixie_dma_scheduler.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixie_dma_scheduler.sv
// ---------------------------------------------------------------------------
// pixie_dma_scheduler
//
// Video-timing and DMA-out scheduler for a PIXIE-style display controller.
// A cycle/line raster counter advances on every CPU machine-cycle tick
// (clk_enable). On each enabled display line a DMA-out burst is requested
// from the CPU starting at line cycle DMA_START. It ends once DMA_BYTES
// acknowledge cycles (SC == 2'b10) have been seen. If the line runs out
// before that, the burst is cut off and a sticky miss flag is raised.
//
// Handshake: DMAO is an active-low request. While it is low, every tick on
// which the CPU reports SC == 2'b10 counts as one accepted transfer. SC is
// ignored while DMAO is high. DMAO rises on the tick after the last
// transfer, so the CPU never sees a request for a transfer beyond DMA_BYTES.
//
// Ports
//   clk          clock; all state changes on the rising edge
//   reset_n      asynchronous active-low reset
//   clk_enable   one CPU machine-cycle tick; state advances only when high
//   SC           CPU state code (2'b10 = DMA acknowledge cycle)
//   disp_on      display enable strobe (wins over disp_off)
//   disp_off     display disable strobe
//   miss_clear   clears dma_miss (wins over a same-tick miss)
//   DMAO         active-low DMA-out request
//   INT          interrupt request, the two lines before the display window
//   EFx          active-low frame flag, 4 lines before start/end of display
//   line         current line, 0..FRAME_LINES-1
//   cycle        current line cycle, 0..LINE_CYCLES-1
//   dma_count    DMA acknowledges accepted on the current line
//   frame_start  one-clock pulse when the raster reaches line 0, cycle 0
//   dma_miss     sticky: a burst was cut off by the end of its line
//   fsm_state    debug view of the per-line burst state
// ---------------------------------------------------------------------------
module pixie_dma_scheduler #(
    parameter int LINE_CYCLES  = 14,
    parameter int FRAME_LINES  = 262,
    parameter int ACTIVE_START = 64,
    parameter int ACTIVE_LINES = 128,
    parameter int DMA_BYTES    = 8,
    parameter int DMA_START    = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       clk_enable,
    input  logic [1:0] SC,
    input  logic       disp_on,
    input  logic       disp_off,
    input  logic       miss_clear,
    output logic       DMAO,
    output logic       INT,
    output logic       EFx,
    output logic [8:0] line,
    output logic [3:0] cycle,
    output logic [3:0] dma_count,
    output logic       frame_start,
    output logic       dma_miss,
    output logic [1:0] fsm_state
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_BURST = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [3:0] LAST_CYCLE = 4'(LINE_CYCLES - 1);
    localparam logic [8:0] LAST_LINE  = 9'(FRAME_LINES - 1);
    localparam logic [3:0] BURST_LEN  = 4'(DMA_BYTES);
    localparam logic [3:0] OPEN_CYCLE = 4'(DMA_START - 1);

    localparam int ACTIVE_END = ACTIVE_START + ACTIVE_LINES - 1;

    // Inclusive line-window test; bounds may be negative for small parameters.
    function automatic logic in_window(input logic [8:0] l, input int lo, input int hi);
        int li;
        li = int'({23'd0, l});
        return (li >= lo) && (li <= hi);
    endfunction

    logic [1:0] state;
    logic       pend_en;
    logic       act_en;

    logic       wrap;
    logic [3:0] cycle_nxt;
    logic [8:0] line_nxt;
    logic       pend_nxt;
    logic       act_nxt;
    logic       ack;
    logic       burst_full;
    logic [3:0] count_nxt;
    logic [1:0] state_nxt;
    logic       miss_set;

    assign fsm_state = state;

    always_comb begin
        wrap      = (cycle == LAST_CYCLE);
        cycle_nxt = wrap ? 4'd0 : cycle + 4'd1;
        line_nxt  = line;
        if (wrap) begin
            line_nxt = (line == LAST_LINE) ? 9'd0 : line + 9'd1;
        end

        pend_nxt = pend_en;
        if (disp_on) begin
            pend_nxt = 1'b1;
        end else if (disp_off) begin
            pend_nxt = 1'b0;
        end

        // The line's enable is latched as the raster enters cycle 0, so
        // strobes arriving mid-line only take effect on the following line.
        act_nxt = wrap ? pend_nxt : act_en;

        ack        = (state == ST_BURST) && (SC == 2'b10);
        burst_full = ack && ((dma_count + 4'd1) == BURST_LEN);

        count_nxt = dma_count;
        if (wrap) begin
            count_nxt = 4'd0;
        end else if (ack && (dma_count < BURST_LEN)) begin
            count_nxt = dma_count + 4'd1;
        end

        state_nxt = state;
        miss_set  = 1'b0;
        if (wrap) begin
            // An ack completing the burst on the very last cycle is not a miss.
            miss_set  = (state == ST_BURST) && !burst_full;
            state_nxt = (pend_nxt && in_window(line_nxt, ACTIVE_START, ACTIVE_END))
                        ? ST_WAIT : ST_IDLE;
        end else begin
            case (state)
                ST_WAIT:  if (cycle == OPEN_CYCLE) state_nxt = ST_BURST;
                ST_BURST: if (burst_full) state_nxt = ST_DONE;
                default:  state_nxt = state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cycle       <= 4'd0;
            line        <= 9'd0;
            dma_count   <= 4'd0;
            state       <= ST_IDLE;
            pend_en     <= 1'b0;
            act_en      <= 1'b0;
            DMAO        <= 1'b1;
            INT         <= 1'b0;
            EFx         <= 1'b1;
            frame_start <= 1'b0;
            dma_miss    <= 1'b0;
        end else if (clk_enable) begin
            cycle       <= cycle_nxt;
            line        <= line_nxt;
            dma_count   <= count_nxt;
            state       <= state_nxt;
            pend_en     <= pend_nxt;
            act_en      <= act_nxt;
            // Outputs are decoded from next-state values so they line up
            // with the registered counters they describe.
            DMAO        <= (state_nxt != ST_BURST);
            INT         <= act_nxt && in_window(line_nxt, ACTIVE_START - 2, ACTIVE_START - 1);
            EFx         <= !(in_window(line_nxt, ACTIVE_START - 4, ACTIVE_START - 1) ||
                             in_window(line_nxt, ACTIVE_END - 3, ACTIVE_END));
            frame_start <= (line_nxt == 9'd0) && (cycle_nxt == 4'd0);
            if (miss_clear) begin
                dma_miss <= 1'b0;
            end else if (miss_set) begin
                dma_miss <= 1'b1;
            end
        end else begin
            frame_start <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pixie_dma_scheduler.sv
// ---------------------------------------------------------------------------
// tb_pixie_dma_scheduler
//
// Bench for pixie_dma_scheduler. The reference model tracks the raster
// position, the per-line enable and the ack count, and derives DMAO directly:
// the request is open whenever the line is enabled and on screen, the cycle
// has reached DMA_START and fewer than DMA_BYTES acks have been accepted.
// ---------------------------------------------------------------------------
module tb_pixie_dma_scheduler;

    localparam int LC = 14;
    localparam int FL = 262;
    localparam int AS = 64;
    localparam int AL = 128;
    localparam int DB = 8;
    localparam int DS = 2;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       reset_n;
    logic       clk_enable;
    logic [1:0] SC;
    logic       disp_on;
    logic       disp_off;
    logic       miss_clear;
    logic       DMAO;
    logic       INT;
    logic       EFx;
    logic [8:0] line;
    logic [3:0] cycle;
    logic [3:0] dma_count;
    logic       frame_start;
    logic       dma_miss;
    logic [1:0] fsm_state;

    always #5 clk = ~clk;

    pixie_dma_scheduler #(
        .LINE_CYCLES(LC), .FRAME_LINES(FL), .ACTIVE_START(AS),
        .ACTIVE_LINES(AL), .DMA_BYTES(DB), .DMA_START(DS)
    ) dut (
        .clk(clk), .reset_n(reset_n), .clk_enable(clk_enable), .SC(SC),
        .disp_on(disp_on), .disp_off(disp_off), .miss_clear(miss_clear),
        .DMAO(DMAO), .INT(INT), .EFx(EFx), .line(line), .cycle(cycle),
        .dma_count(dma_count), .frame_start(frame_start), .dma_miss(dma_miss),
        .fsm_state(fsm_state)
    );

    // ---------------- scoreboard counters ----------------
    int tests  = 0;
    int errors = 0;
    bit chk_en = 1'b0;
    bit lit_tbl = 1'b0;

    task automatic check(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (model line %0d cycle %0d, t=%0t)",
                     nm, act, exp, m_line, m_cycle, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_cycle, m_line, m_count;
    bit m_pend, m_en, m_miss, m_fs;

    function automatic bit on_screen(input int l);
        return (l >= AS) && (l <= AS + AL - 1);
    endfunction

    function automatic bit m_open();
        return m_en && on_screen(m_line) && (m_cycle >= DS) && (m_count < DB);
    endfunction

    task automatic model_reset();
        m_cycle = 0; m_line = 0; m_count = 0;
        m_pend = 0; m_en = 0; m_miss = 0; m_fs = 0;
    endtask

    task automatic model_tick(input bit on, input bit off, input bit mclr, input logic [1:0] sc);
        bit open, ack, mset;
        int nc;
        open = m_open();
        ack  = open && (sc == 2'b10);
        nc   = m_count + (ack ? 1 : 0);
        if (on) m_pend = 1;
        else if (off) m_pend = 0;
        mset = 0;
        m_fs = 0;
        if (m_cycle == LC - 1) begin
            mset    = open && (nc < DB);
            m_cycle = 0;
            m_count = 0;
            m_line  = (m_line + 1) % FL;
            m_en    = m_pend;
            m_fs    = (m_line == 0);
        end else begin
            m_cycle = m_cycle + 1;
            m_count = nc;
        end
        if (mclr) m_miss = 0;
        else if (mset) m_miss = 1;
    endtask

    // ---------------- compare process ----------------
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (chk_en) begin
                check("cycle", int'(cycle), m_cycle);
                check("line", int'(line), m_line);
                check("dma_count", int'(dma_count), m_count);
                check("DMAO", int'(DMAO), m_open() ? 0 : 1);
                check("INT", int'(INT), (m_en && (m_line == AS - 2 || m_line == AS - 1)) ? 1 : 0);
                check("EFx", int'(EFx),
                      ((m_line >= AS - 4 && m_line <= AS - 1) ||
                       (m_line >= AS + AL - 4 && m_line <= AS + AL - 1)) ? 0 : 1);
                check("frame_start", int'(frame_start), int'(m_fs));
                check("dma_miss", int'(dma_miss), int'(m_miss));
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Called just after a falling edge; returns at the next falling edge.
    task automatic step(input bit ce, input bit on, input bit off, input bit mclr,
                        input logic [1:0] sc);
        clk_enable = ce; disp_on = on; disp_off = off; miss_clear = mclr; SC = sc;
        if (ce) model_tick(on, off, mclr, sc);
        else m_fs = 0;
        @(negedge clk);
    endtask

    // Hand-computed INT/EFx values for a frame with the display enabled.
    task automatic table_checks();
        if (lit_tbl && m_cycle == 7) begin
            case (m_line)
                59:  begin check("lit_EFx_59", int'(EFx), 1);  check("lit_INT_59", int'(INT), 0); end
                60:  begin check("lit_EFx_60", int'(EFx), 0);  check("lit_INT_60", int'(INT), 0); end
                61:  check("lit_INT_61", int'(INT), 0);
                62:  check("lit_INT_62", int'(INT), 1);
                63:  begin check("lit_INT_63", int'(INT), 1);  check("lit_EFx_63", int'(EFx), 0); end
                64:  begin check("lit_INT_64", int'(INT), 0);  check("lit_EFx_64", int'(EFx), 1); end
                187: check("lit_EFx_187", int'(EFx), 1);
                188: check("lit_EFx_188", int'(EFx), 0);
                191: check("lit_EFx_191", int'(EFx), 0);
                192: check("lit_EFx_192", int'(EFx), 1);
                default: ;
            endcase
        end
    endtask

    task automatic run_to(input int l, input int c, input logic [1:0] sc);
        while (!(m_line == l && m_cycle == c)) begin
            table_checks();
            step(1, 0, 0, 0, sc);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int n;
        reset_n = 1'b0; clk_enable = 1'b0; SC = 2'b00;
        disp_on = 1'b0; disp_off = 1'b0; miss_clear = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_line", int'(line), 0);
        check("rst_cycle", int'(cycle), 0);
        check("rst_DMAO", int'(DMAO), 1);
        check("rst_INT", int'(INT), 0);
        check("rst_EFx", int'(EFx), 1);
        check("rst_fs", int'(frame_start), 0);
        chk_en  = 1'b1;
        reset_n = 1'b1;

        // First tick after reset lands on cycle 1 with no frame pulse.
        step(1, 1, 0, 0, 2'b10);
        check("post_rst_cycle", int'(cycle), 1);
        check("post_rst_fs", int'(frame_start), 0);

        // Always-ack burst on line 64.
        run_to(AS, 0, 2'b10);
        for (int c = 0; c < LC; c++) begin
            check("A_DMAO", int'(DMAO), (c >= 2 && c <= 9) ? 0 : 1);
            if (c == 10) check("A_count", int'(dma_count), 8);
            step(1, 0, 0, 0, 2'b10);
        end
        check("A_miss", int'(dma_miss), 0);

        // No acks: burst runs to end of line and flags a miss.
        lit_tbl = 1'b1;
        run_to(AS, 0, 2'b00);
        lit_tbl = 1'b0;
        for (int c = 0; c < LC; c++) begin
            check("B_DMAO", int'(DMAO), (c >= 2) ? 0 : 1);
            step(1, 0, 0, 0, 2'b00);
        end
        check("B_miss_set", int'(dma_miss), 1);
        step(1, 0, 0, 1, 2'b00);
        check("B_miss_clr", int'(dma_miss), 0);

        // Frame period measured between two frame_start pulses.
        n = 0;
        while (!frame_start && n < 5000) begin step(1, 0, 0, 0, 2'b00); n++; end
        check("fs_seen", int'(frame_start), 1);
        n = 0;
        do begin step(1, 0, 0, 0, 2'b00); n++; end while (!frame_start && n < 5000);
        check("fs_period", n, FL * LC);

        // disp_off mid-line 100: that line completes, line 101 stays idle.
        run_to(100, 5, 2'b10);
        step(1, 0, 1, 0, 2'b10);
        run_to(100, 9, 2'b10);
        check("D_DMAO_9", int'(DMAO), 0);
        step(1, 0, 0, 0, 2'b10);
        check("D_DMAO_10", int'(DMAO), 1);
        run_to(101, 0, 2'b10);
        for (int c = 0; c < LC; c++) begin
            check("D_DMAO_101", int'(DMAO), 1);
            step(1, 0, 0, 0, 2'b10);
        end

        // disp_on and disp_off together: enabled from the next line.
        run_to(120, 6, 2'b00);
        step(1, 1, 1, 0, 2'b00);
        run_to(120, 2, 2'b00);
        run_to(121, 2, 2'b00);
        check("E_DMAO_121", int'(DMAO), 0);

        // Asynchronous reset in the middle of a burst.
        run_to(122, 2, 2'b00);
        repeat (3) step(1, 0, 0, 0, 2'b10);
        check("F_count3", int'(dma_count), 3);
        check("F_DMAO_low", int'(DMAO), 0);
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check("F_DMAO", int'(DMAO), 1);
        check("F_line", int'(line), 0);
        check("F_cycle", int'(cycle), 0);
        check("F_count", int'(dma_count), 0);
        check("F_miss", int'(dma_miss), 0);
        @(negedge clk);
        reset_n = 1'b1;

        // Randomized traffic against the model.
        step(1, 1, 0, 0, 2'b00);
        for (int i = 0; i < 20000; i++) begin
            step(($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 150) == 0),
                 ($urandom_range(0, 300) == 0),
                 ($urandom_range(0, 40) == 0),
                 ($urandom_range(0, 1) != 0) ? 2'b10 : 2'($urandom_range(0, 3)));
        end

        chk_en = 1'b0;
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
